// File: rtl/matrix_pkg.sv
// ==========================================================================
// Module  : matrix_pkg
// Brief   : Shared constants, host FSM encoding and byte packing helper
// Revision: 1.0
// ==========================================================================
`default_nettype none

package matrix_pkg;

  localparam int N_ELEM      = 9;
  localparam int N_TX_BYTES  = 20;
  localparam int N_PAD       = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TX_LOAD    = 3'd1,
    TX_WAIT_HI = 3'd2,
    TX_WAIT_LO = 3'd3,
    RX_WAIT    = 3'd4,
    DONE       = 3'd5
  } host_state_t;

  // Keeps only the low `width` bits of an element already widened to a byte.
  function automatic logic [7:0] pack_elem(input logic [7:0] raw, input int width);
    return raw & 8'((9'h1 << width) - 9'h1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_uart_host_if.sv
// ==========================================================================
// Module  : matrix_uart_host_if
// Brief   : Host request/result signals plus the uart_tx/uart_rx byte links
// Revision: 1.0
// ==========================================================================
`default_nettype none

interface matrix_uart_host_if
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 4
);
  logic                           start;
  logic [N_ELEM*DATA_WIDTH-1:0]   a_flat;
  logic [N_ELEM*DATA_WIDTH-1:0]   b_flat;
  logic [7:0]                     tx_data;
  logic                           tx_start;
  logic                           tx_busy;
  logic [7:0]                     rx_data;
  logic                           rx_ready;
  logic [N_ELEM*8-1:0]            c_flat;
  logic                           busy;
  logic                           done;
  logic [N_ELEM-1:0]              mismatch;
  logic                           timeout;

  modport master (
    input  start, a_flat, b_flat, tx_busy, rx_data, rx_ready,
    output tx_data, tx_start, c_flat, busy, done, mismatch, timeout
  );

  modport slave (
    output start, a_flat, b_flat, tx_busy, rx_data, rx_ready,
    input  tx_data, tx_start, c_flat, busy, done, mismatch, timeout
  );
endinterface

`default_nettype wire

// File: rtl/matrix_golden_mac.sv
// ==========================================================================
// Module  : matrix_golden_mac
// Brief   : Sequential 27-step MAC producing the 3x3 product modulo 256
// Revision: 1.0
// ==========================================================================
`default_nettype none

module matrix_golden_mac
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         start,
  input  wire logic [N_ELEM*DATA_WIDTH-1:0] a_flat,
  input  wire logic [N_ELEM*DATA_WIDTH-1:0] b_flat,
  output logic                              done,
  output logic [N_ELEM-1:0][7:0]            result
);

  logic [N_ELEM*DATA_WIDTH-1:0] r_a;
  logic [N_ELEM*DATA_WIDTH-1:0] r_b;
  logic [1:0]                   r_i;
  logic [1:0]                   r_j;
  logic [1:0]                   r_k;
  logic [9:0]                   r_acc;
  logic                         r_run;
  logic                         r_done;
  logic [N_ELEM-1:0][7:0]       r_result;

  logic [3:0]                   w_a_idx;
  logic [3:0]                   w_b_idx;
  logic [3:0]                   w_c_idx;
  logic [DATA_WIDTH-1:0]        w_a_elem;
  logic [DATA_WIDTH-1:0]        w_b_elem;
  logic [2*DATA_WIDTH-1:0]      w_prod;
  logic [9:0]                   w_acc_next;

  always_comb begin
    w_a_idx    = 4'(r_i * 3 + r_k);
    w_b_idx    = 4'(r_k * 3 + r_j);
    w_c_idx    = 4'(r_i * 3 + r_j);
    w_a_elem   = r_a[w_a_idx*DATA_WIDTH +: DATA_WIDTH];
    w_b_elem   = r_b[w_b_idx*DATA_WIDTH +: DATA_WIDTH];
    w_prod     = (2*DATA_WIDTH)'(w_a_elem) * (2*DATA_WIDTH)'(w_b_elem);
    // The first term of each dot product restarts the accumulator.
    w_acc_next = ((r_k == 2'd0) ? 10'd0 : r_acc) + 10'(w_prod);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_i      <= 2'd0;
      r_j      <= 2'd0;
      r_k      <= 2'd0;
      r_acc    <= 10'd0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a   <= a_flat;
        r_b   <= b_flat;
        r_i   <= 2'd0;
        r_j   <= 2'd0;
        r_k   <= 2'd0;
        r_acc <= 10'd0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_acc <= w_acc_next;
        if (r_k == 2'd2) begin
          r_result[w_c_idx] <= w_acc_next[7:0];
          r_k <= 2'd0;
          if (r_j == 2'd2) begin
            r_j <= 2'd0;
            if (r_i == 2'd2) begin
              r_i    <= 2'd0;
              r_run  <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_i <= r_i + 2'd1;
            end
          end else begin
            r_j <= r_j + 2'd1;
          end
        end else begin
          r_k <= r_k + 2'd1;
        end
      end
    end
  end

  assign done   = r_done;
  assign result = r_result;

endmodule

`default_nettype wire

// File: rtl/matrix_uart_host.sv
// ==========================================================================
// Module  : matrix_uart_host
// Brief   : Streams A/B to the multiplier over UART and checks the 9 results
// Revision: 1.0
// ==========================================================================
`default_nettype none

module matrix_uart_host
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH    = 4,
  parameter int CLOCK_FREQ    = 100_000_000,
  parameter int RX_TIMEOUT_MS = 50
) (
  input  wire logic            clk,
  input  wire logic            rst,
  matrix_uart_host_if.master   bus
);

  localparam logic [31:0] c_timeout_cycles = 32'(CLOCK_FREQ / 1000 * RX_TIMEOUT_MS);

  host_state_t                  r_state;
  host_state_t                  w_state_next;
  logic [N_ELEM*DATA_WIDTH-1:0] r_a;
  logic [N_ELEM*DATA_WIDTH-1:0] r_b;
  logic [4:0]                   r_byte_cnt;
  logic [3:0]                   r_rx_cnt;
  logic [7:0]                   r_tx_data;
  logic                         r_tx_start;
  logic [N_ELEM*8-1:0]          r_c_flat;
  logic [N_ELEM-1:0]            r_mismatch;
  logic                         r_timeout;
  logic                         r_rx_ready_q;
  logic [31:0]                  r_to_cnt;
  logic                         r_exp_ready;

  logic                         w_accept;
  logic                         w_load;
  logic                         w_byte_done;
  logic                         w_capture;
  logic                         w_to_hit;
  logic                         w_rx_edge;
  logic                         w_mac_done;
  logic [N_ELEM-1:0][7:0]       w_exp;
  logic [DATA_WIDTH-1:0]        w_elem;
  logic [7:0]                   w_tx_byte;
  logic [N_ELEM-1:0]            w_unrecv_mask;

  matrix_golden_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_golden (
    .clk    (clk),
    .rst    (rst),
    .start  (w_accept),
    .a_flat (bus.a_flat),
    .b_flat (bus.b_flat),
    .done   (w_mac_done),
    .result (w_exp)
  );

  assign w_rx_edge = bus.rx_ready & ~r_rx_ready_q;

  always_comb begin
    w_elem = '0;
    if (r_byte_cnt < 5'(N_ELEM)) begin
      w_elem = r_a[r_byte_cnt*DATA_WIDTH +: DATA_WIDTH];
    end else if (r_byte_cnt < 5'(N_TX_BYTES - N_PAD)) begin
      w_elem = r_b[(r_byte_cnt - 5'(N_ELEM))*DATA_WIDTH +: DATA_WIDTH];
    end
    w_tx_byte = pack_elem(8'(w_elem), DATA_WIDTH);
    for (int k = 0; k < N_ELEM; k++) begin
      w_unrecv_mask[k] = (4'(k) >= r_rx_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_byte_done  = 1'b0;
    w_capture    = 1'b0;
    w_to_hit     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = TX_LOAD;
        end
      end
      TX_LOAD: begin
        if (!bus.tx_busy) begin
          w_load       = 1'b1;
          w_state_next = TX_WAIT_HI;
        end
      end
      TX_WAIT_HI: begin
        if (bus.tx_busy) w_state_next = TX_WAIT_LO;
      end
      TX_WAIT_LO: begin
        // Results cannot be judged before the golden product exists.
        if (!bus.tx_busy) begin
          if (r_byte_cnt != 5'(N_TX_BYTES - 1)) begin
            w_byte_done  = 1'b1;
            w_state_next = TX_LOAD;
          end else if (r_exp_ready) begin
            w_byte_done  = 1'b1;
            w_state_next = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        if (w_rx_edge) begin
          w_capture = 1'b1;
          if (r_rx_cnt == 4'(N_ELEM - 1)) w_state_next = DONE;
        end else if (r_to_cnt >= c_timeout_cycles) begin
          w_to_hit     = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_byte_cnt   <= 5'd0;
      r_rx_cnt     <= 4'd0;
      r_tx_data    <= 8'd0;
      r_tx_start   <= 1'b0;
      r_c_flat     <= '0;
      r_mismatch   <= '0;
      r_timeout    <= 1'b0;
      r_rx_ready_q <= 1'b0;
      r_to_cnt     <= 32'd0;
      r_exp_ready  <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_rx_ready_q <= bus.rx_ready;
      if (w_mac_done) r_exp_ready <= 1'b1;
      if (w_accept) begin
        r_a         <= bus.a_flat;
        r_b         <= bus.b_flat;
        r_c_flat    <= '0;
        r_mismatch  <= '0;
        r_timeout   <= 1'b0;
        r_byte_cnt  <= 5'd0;
        r_rx_cnt    <= 4'd0;
        r_exp_ready <= 1'b0;
      end
      if (w_load) begin
        r_tx_data  <= w_tx_byte;
        r_tx_start <= 1'b1;
      end
      if (w_byte_done) r_byte_cnt <= r_byte_cnt + 5'd1;
      if (w_byte_done && (w_state_next == RX_WAIT)) begin
        r_to_cnt <= 32'd0;
      end else if (r_state == RX_WAIT) begin
        if (w_capture)              r_to_cnt <= 32'd0;
        else if (r_to_cnt != '1)    r_to_cnt <= r_to_cnt + 32'd1;
      end
      if (w_capture) begin
        r_c_flat[r_rx_cnt*8 +: 8] <= bus.rx_data;
        r_mismatch[r_rx_cnt]      <= (bus.rx_data != w_exp[r_rx_cnt]);
        r_rx_cnt                  <= r_rx_cnt + 4'd1;
      end
      if (w_to_hit) begin
        r_timeout  <= 1'b1;
        r_mismatch <= r_mismatch | w_unrecv_mask;
      end
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = r_tx_start;
  assign bus.c_flat   = r_c_flat;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DONE);
  assign bus.mismatch = r_mismatch;
  assign bus.timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_matrix_uart_host.sv
// ==========================================================================
// Module  : tb_matrix_uart_host
// Brief   : Table-driven and randomized bench for matrix_uart_host
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_matrix_uart_host;
  import matrix_pkg::*;

  localparam int DW     = 4;
  localparam int TX_CYC = 30;
  localparam int N_VEC  = 10;

  typedef struct {
    logic [9*DW-1:0] a;
    logic [9*DW-1:0] b;
    logic [8:0][7:0] resp;
    int              n_resp;
    int              hold;
    bit              stray;
    bit              dbl_start;
    logic [8:0]      exp_mis;
    bit              exp_to;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] tx_log [$];
  int         tx_viol  = 0;
  int         done_cnt = 0;
  int         checks   = 0;
  int         errors   = 0;
  vec_t       vecs [N_VEC];

  matrix_uart_host_if #(.DATA_WIDTH(DW)) bus ();

  matrix_uart_host #(
    .DATA_WIDTH    (DW),
    .CLOCK_FREQ    (100_000),
    .RX_TIMEOUT_MS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  // uart_tx stand-in: logs each byte, holds busy, watches for protocol breaches.
  initial begin
    logic [7:0] d;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_start === 1'b1 && rst) begin
        d = bus.tx_data;
        tx_log.push_back(d);
        bus.tx_busy = 1'b1;
        for (int c = 0; c < TX_CYC; c++) begin
          @(posedge clk); #1;
          if (!rst) break;
          if (bus.tx_start !== 1'b0 || bus.tx_data !== d) tx_viol = tx_viol + 1;
        end
        bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference product: plain integer dot products, reduced modulo 256.
  function automatic logic [8:0][7:0] golden(input logic [9*DW-1:0] a, input logic [9*DW-1:0] b);
    logic [8:0][7:0] c;
    int s;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(a[(i*3+k)*DW +: DW]) * int'(b[(k*3+j)*DW +: DW]);
        c[i*3+j] = 8'(s % 256);
      end
    end
    return c;
  endfunction

  function automatic vec_t rand_vec(input int hold, input bit corrupt, input int n);
    vec_t v;
    logic [63:0] r;
    logic [8:0][7:0] g;
    int idx;
    r = {$urandom, $urandom}; v.a = r[9*DW-1:0];
    r = {$urandom, $urandom}; v.b = r[9*DW-1:0];
    g = golden(v.a, v.b);
    v.resp = g;
    if (corrupt) begin
      idx = int'($urandom_range(8));
      v.resp[idx] = g[idx] ^ 8'(1 + $urandom_range(254));
    end
    v.n_resp = n; v.hold = hold; v.stray = 1'b0; v.dbl_start = 1'b0;
    for (int k = 0; k < 9; k++) v.exp_mis[k] = (k >= n) || (v.resp[k] != g[k]);
    v.exp_to = (n < 9);
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input int id);
    int base_tx, base_done, base_viol, w;
    logic [159:0] act_s, exp_s;
    logic [71:0] exp_c;
    base_tx = tx_log.size(); base_done = done_cnt; base_viol = tx_viol;
    @(posedge clk); #1;
    bus.a_flat = v.a; bus.b_flat = v.b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk($sformatf("v%0d_busy_rise", id), 160'(bus.busy), 160'd1);
    if (v.stray) begin
      bus.rx_data = 8'hEE; bus.rx_ready = 1'b1;
      repeat (2) @(posedge clk); #1;
      bus.rx_ready = 1'b0;
    end
    if (v.dbl_start) begin
      repeat (5) @(posedge clk); #1;
      bus.a_flat = ~v.a; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    w = 0;
    while (((tx_log.size() - base_tx) < 20 || bus.tx_busy) && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    chk($sformatf("v%0d_tx_in_time", id), 160'(w < 1000), 160'd1);
    act_s = '0; exp_s = '0;
    for (int k = 0; k < 20; k++) begin
      if (base_tx + k < tx_log.size()) act_s[k*8 +: 8] = tx_log[base_tx + k];
      if (k < 9)       exp_s[k*8 +: 8] = 8'(v.a[k*DW +: DW]);
      else if (k < 18) exp_s[k*8 +: 8] = 8'(v.b[(k-9)*DW +: DW]);
    end
    chk($sformatf("v%0d_tx_stream", id), act_s, exp_s);
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < v.n_resp; k++) begin
      bus.rx_data = v.resp[k]; bus.rx_ready = 1'b1;
      repeat (v.hold) @(posedge clk); #1;
      bus.rx_ready = 1'b0;
      repeat (3) @(posedge clk); #1;
    end
    w = 0;
    while (done_cnt == base_done && w < 600) begin
      @(posedge clk); #1; w++;
    end
    chk($sformatf("v%0d_done_in_time", id), 160'(w < 600), 160'd1);
    repeat (4) @(posedge clk); #1;
    exp_c = '0;
    for (int k = 0; k < v.n_resp; k++) exp_c[k*8 +: 8] = v.resp[k];
    chk($sformatf("v%0d_done_pulses", id), 160'(done_cnt - base_done), 160'd1);
    chk($sformatf("v%0d_c_flat", id), 160'(bus.c_flat), 160'(exp_c));
    chk($sformatf("v%0d_mismatch", id), 160'(bus.mismatch), 160'(v.exp_mis));
    chk($sformatf("v%0d_timeout", id), 160'(bus.timeout), 160'(v.exp_to));
    chk($sformatf("v%0d_idle_busy", id), 160'(bus.busy), 160'd0);
    chk($sformatf("v%0d_tx_count", id), 160'(tx_log.size() - base_tx), 160'd20);
    chk($sformatf("v%0d_tx_protocol", id), 160'(tx_viol - base_viol), 160'd0);
  endtask

  initial begin
    int n_seen, w;
    vec_t rv;
    bus.start = 1'b0; bus.a_flat = '0; bus.b_flat = '0;
    bus.rx_data = 8'd0; bus.rx_ready = 1'b0;
    rst = 1'b0;

    vecs[0] = '{a: 36'h100010001, b: 36'h987654321, resp: 72'h090807060504030201,
                n_resp: 9, hold: 1, stray: 1'b0, dbl_start: 1'b0, exp_mis: 9'b0, exp_to: 1'b0};
    vecs[1] = '{a: 36'hFFFFFFFFF, b: 36'hFFFFFFFFF, resp: {9{8'hA3}},
                n_resp: 9, hold: 2, stray: 1'b1, dbl_start: 1'b0, exp_mis: 9'b0, exp_to: 1'b0};
    vecs[2] = '{a: 36'hFFFFFFFFF, b: 36'hFFFFFFFFF, resp: 72'hA3A3A3A300A3A3A3A3,
                n_resp: 9, hold: 1, stray: 1'b0, dbl_start: 1'b0, exp_mis: 9'b000010000, exp_to: 1'b0};
    vecs[3] = '{a: 36'h100010001, b: 36'h987654321, resp: 72'h090807060504030201,
                n_resp: 5, hold: 1, stray: 1'b0, dbl_start: 1'b0, exp_mis: 9'b111100000, exp_to: 1'b1};
    vecs[4] = rand_vec(10, 1'b0, 9);
    vecs[4].dbl_start = 1'b1;
    vecs[5] = rand_vec(2, 1'b1, 9);
    vecs[6] = rand_vec(3, 1'b0, 9);
    vecs[7] = rand_vec(1, 1'b1, 7);
    vecs[8] = rand_vec(1, 1'b0, 9);
    vecs[9] = rand_vec(4, 1'b1, 9);

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs",
        160'({bus.tx_data, bus.tx_start, bus.c_flat, bus.busy, bus.done, bus.mismatch, bus.timeout}),
        160'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("idle_after_reset", 160'({bus.busy, bus.done, bus.tx_start}), 160'd0);

    for (int i = 0; i < N_VEC; i++) run_txn(vecs[i], i);

    // Reset while byte 7 is being handed to the UART.
    rv = rand_vec(1, 1'b0, 9);
    @(posedge clk); #1;
    bus.a_flat = rv.a; bus.b_flat = rv.b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_seen = 0; w = 0;
    while (n_seen < 8 && w < 1000) begin
      @(posedge clk); #1; w++;
      if (bus.tx_start === 1'b1) n_seen++;
    end
    chk("rst_reach_byte7", 160'(n_seen), 160'd8);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_outputs",
        160'({bus.tx_data, bus.tx_start, bus.c_flat, bus.busy, bus.done, bus.mismatch, bus.timeout}),
        160'd0);
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    run_txn(rv, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
